// File: rtl/arbiter_pkg.sv
// Shared definitions for the arbiter request serializer: VC IDs, ID width and FSM encoding.
package arbiter_pkg;

  localparam int unsigned CH_W = 2;

  localparam logic [CH_W-1:0] VCHANEL0 = 2'b00;
  localparam logic [CH_W-1:0] VCHANEL1 = 2'b01;
  localparam logic [CH_W-1:0] VCHANEL2 = 2'b10;
  localparam logic [CH_W-1:0] VCHANEL3 = 2'b11;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] IDLE = 2'd0;
  localparam logic [ST_W-1:0] SEND = 2'd1;
  localparam logic [ST_W-1:0] LAST = 2'd2;

endpackage

// File: rtl/arbiter_interface.sv
// Captures a packed list of VC IDs on init and replays them to the arbiter one per enabled cycle.
module arbiter_interface
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enb,
  input  logic                        init,
  input  logic [CH_W*NUM_ENTRIES-1:0] tester_input,
  output logic [CH_W-1:0]             arbiter_input,
  output logic                        arbiter_valid,
  output logic                        done
);

  localparam int unsigned VEC_W = CH_W * NUM_ENTRIES;
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ENTRIES - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] index_q, index_d;
  logic [VEC_W-1:0] cap_q, cap_d;
  logic [CH_W-1:0]  arb_d;
  logic             valid_d;
  logic             done_d;

  // State and registered outputs; everything holds while enb is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      index_q       <= '0;
      cap_q         <= '0;
      arbiter_input <= '0;
      arbiter_valid <= 1'b0;
      done          <= 1'b0;
    end else if (enb) begin
      state_q       <= state_d;
      index_q       <= index_d;
      cap_q         <= cap_d;
      arbiter_input <= arb_d;
      arbiter_valid <= valid_d;
      done          <= done_d;
    end
  end

  // Next state; the capture register shifts down so the current entry is always its low slice.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    cap_d   = cap_q;
    arb_d   = '0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (init) begin
          cap_d   = tester_input;
          index_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        arb_d   = cap_q[CH_W-1:0];
        valid_d = 1'b1;
        cap_d   = cap_q >> CH_W;
        if (index_q == LAST_IDX) begin
          index_d = '0;
          state_d = LAST;
        end else begin
          index_d = index_q + CNT_W'(1);
        end
      end
      LAST: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arbiter_interface.sv
// Directed bench for arbiter_interface: sequence order, stalls, ignored init, reset and back-to-back runs.
module tb_arbiter_interface;
  import arbiter_pkg::*;

  localparam int unsigned N     = 64;
  localparam int unsigned VEC_W = CH_W * N;

  logic             clk = 1'b0;
  logic             rst;
  logic             enb;
  logic             init;
  logic [VEC_W-1:0] tester_input;
  logic [CH_W-1:0]  arbiter_input;
  logic             arbiter_valid;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;
  int vcount;

  logic [VEC_W-1:0] vec1, vec2, vec3;

  arbiter_interface #(.NUM_ENTRIES(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .enb           (enb),
    .init          (init),
    .tester_input  (tester_input),
    .arbiter_input (arbiter_input),
    .arbiter_valid (arbiter_valid),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CH_W-1:0] ent(input logic [VEC_W-1:0] v, input int k);
    return v[k*CH_W +: CH_W];
  endfunction

  // Advance one edge and sample shortly after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_entry(input string tag, input logic [VEC_W-1:0] v, input int k);
    check({tag, "_data"}, 32'(arbiter_input), 32'(ent(v, k)));
    check({tag, "_valid"}, 32'(arbiter_valid), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic start(input logic [VEC_W-1:0] v);
    tester_input = v;
    init = 1'b1;
    step();
    init = 1'b0;
    check("init_edge_valid", 32'(arbiter_valid), 32'd0);
  endtask

  task automatic check_done();
    check("done_pulse", 32'(done), 32'd1);
    check("done_valid", 32'(arbiter_valid), 32'd0);
    check("done_data", 32'(arbiter_input), 32'd0);
  endtask

  initial begin
    // Hand-chosen vectors; entries 0..7 and 63 of vec1 follow the basic-sequence plan.
    vec1 = '0;
    for (int k = 8; k < 63; k++) vec1[k*CH_W +: CH_W] = CH_W'((k * 3 + 1) % 4);
    vec1[0*CH_W +: CH_W] = VCHANEL2;
    vec1[1*CH_W +: CH_W] = VCHANEL0;
    vec1[2*CH_W +: CH_W] = VCHANEL1;
    vec1[3*CH_W +: CH_W] = VCHANEL2;
    vec1[4*CH_W +: CH_W] = VCHANEL1;
    vec1[5*CH_W +: CH_W] = VCHANEL2;
    vec1[6*CH_W +: CH_W] = VCHANEL3;
    vec1[7*CH_W +: CH_W] = VCHANEL2;
    vec1[63*CH_W +: CH_W] = VCHANEL1;
    for (int k = 0; k < 64; k++) vec2[k*CH_W +: CH_W] = CH_W'(k % 4);
    for (int k = 0; k < 64; k++) vec3[k*CH_W +: CH_W] = CH_W'((k * 5 + 2) % 3);

    rst = 1'b1; enb = 1'b1; init = 1'b0; tester_input = '0;
    #12;
    check("rst_data", 32'(arbiter_input), 32'd0);
    check("rst_valid", 32'(arbiter_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();
    check("idle_valid", 32'(arbiter_valid), 32'd0);

    // Basic sequence with explicit constants for the first entries and the last one.
    start(vec1);
    step(); check("b_e0", 32'(arbiter_input), 32'd2);
    step(); check("b_e1", 32'(arbiter_input), 32'd0);
    step(); check("b_e2", 32'(arbiter_input), 32'd1);
    step(); check("b_e3", 32'(arbiter_input), 32'd2);
    step(); check("b_e4", 32'(arbiter_input), 32'd1);
    step(); check("b_e5", 32'(arbiter_input), 32'd2);
    step(); check("b_e6", 32'(arbiter_input), 32'd3);
    step(); check("b_e7", 32'(arbiter_input), 32'd2);
    check("b_valid7", 32'(arbiter_valid), 32'd1);
    for (int k = 8; k < 63; k++) begin step(); check_entry("b_mid", vec1, k); end
    step(); check("b_e63", 32'(arbiter_input), 32'd1);
    check("b_valid63", 32'(arbiter_valid), 32'd1);
    step(); check_done();
    step(); check("done_one_cycle", 32'(done), 32'd0);
    check("after_valid", 32'(arbiter_valid), 32'd0);

    // Enable stall after entry 10.
    vcount = 0;
    start(vec2);
    for (int k = 0; k < 64; k++) begin
      step();
      check_entry("s_e", vec2, k);
      if (arbiter_valid) vcount++;
      if (k == 10) begin
        enb = 1'b0;
        for (int j = 0; j < 5; j++) begin
          step();
          check("stall_data", 32'(arbiter_input), 32'(ent(vec2, 10)));
          check("stall_valid", 32'(arbiter_valid), 32'd1);
        end
        enb = 1'b1;
      end
    end
    check("stall_vcount", 32'(vcount), 32'd64);
    step(); check_done();

    // Init and input changes mid-sequence are ignored.
    start(vec3);
    for (int k = 0; k < 64; k++) begin
      step();
      check_entry("i_e", vec3, k);
      if (k == 20) begin init = 1'b1; tester_input = '1; end
      if (k == 22) init = 1'b0;
    end
    step(); check_done();
    step();

    // Asynchronous reset at entry 30, then restart from entry 0.
    start(vec1);
    for (int k = 0; k <= 30; k++) begin step(); check_entry("r_e", vec1, k); end
    #2 rst = 1'b1;
    #1;
    check("mrst_data", 32'(arbiter_input), 32'd0);
    check("mrst_valid", 32'(arbiter_valid), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    step();
    #2 rst = 1'b0;
    step();
    check("post_rst_valid", 32'(arbiter_valid), 32'd0);
    start(vec2);
    for (int k = 0; k < 64; k++) begin step(); check_entry("rr_e", vec2, k); end
    step(); check_done();

    // Back-to-back: init during the done cycle.
    init = 1'b1; tester_input = vec3;
    step();
    init = 1'b0;
    check("b2b_gap_valid", 32'(arbiter_valid), 32'd0);
    check("b2b_gap_done", 32'(done), 32'd0);
    for (int k = 0; k < 64; k++) begin step(); check_entry("bb_e", vec3, k); end
    step(); check_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
